// File: rtl/mux_sync_launcher_pkg.sv
// Shared state encodings and defaults for the mux-synchronizer launch side.
// Default DATA_W and SYNC_STAGES are also used by the receiver side.
package mux_sync_launcher_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_DROP   = 2'd2;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mux_sync_launcher_ack_sync.sv
// ack_sync: SYNC_STAGES-deep flop chain bringing rx_ack into the launch domain.
// Synchronous active-high reset clears every stage to 0.
module ack_sync
    import mux_sync_launcher_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    // Shift the async level one stage deeper each cycle.
    always_comb begin
        chain_d    = chain_q << 1;
        chain_d[0] = async_in;
    end

    // Chain registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sync_out = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/mux_sync_launcher.sv
// mux_sync_launcher: launch-domain side of the recirculation-mux synchronizer.
// Optional ack timeout in LAUNCH is enabled by defining MUX_SYNC_ACK_TIMEOUT_EN.
module mux_sync_launcher
    import mux_sync_launcher_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_MIN    = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_enable,
    input  logic              rx_ack,
    output logic              busy,
    output logic              timeout
);

    localparam int HOLD_W = cnt_w(HOLD_MIN);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_MIN);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              en_q;
    logic              en_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;

    logic ack_s;
    logic take;
    logic hold_met;
    logic ack_exit;
    logic to_fire;

    ack_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(rx_ack),
        .sync_out(ack_s)
    );

    // A stale ack seen in IDLE blocks new words until it clears.
    assign in_ready = ~reset & (state_q == ST_IDLE) & ~ack_s;
    assign take     = in_valid & in_ready;
    assign hold_met = (hold_q >= HOLD_MAX);
    assign ack_exit = (state_q == ST_LAUNCH) & ack_s & hold_met;

`ifdef MUX_SYNC_ACK_TIMEOUT_EN
    localparam int TO_W =
        (cnt_w(TIMEOUT_CYC) < 8) ? 8 : cnt_w(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;
    logic            to_pulse_q;
    logic            to_pulse_d;

    assign to_fire = (state_q == ST_LAUNCH) & (to_cnt_q == TO_LIMIT);

    // Count LAUNCH cycles from 1; a real ack on the limit cycle wins.
    always_comb begin
        to_cnt_d   = to_cnt_q;
        to_pulse_d = to_fire & ~ack_exit;
        if (take) begin
            to_cnt_d = TO_W'(1);
        end else if (state_q == ST_LAUNCH && to_cnt_q < TO_LIMIT) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Timeout counter and single-cycle pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q   <= '0;
            to_pulse_q <= 1'b0;
        end else begin
            to_cnt_q   <= to_cnt_d;
            to_pulse_q <= to_pulse_d;
        end
    end

    assign timeout = to_pulse_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign to_fire            = 1'b0;
    assign timeout            = 1'b0;
`endif

    // Handshake FSM: capture, hold enable until acked, wait for ack release.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        en_d    = en_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    data_d  = in_data;
                    en_d    = 1'b1;
                    hold_d  = HOLD_W'(1);
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (!hold_met) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (ack_exit || to_fire) begin
                    en_d    = 1'b0;
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, frozen data word, enable and hold counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            en_q    <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            en_q    <= en_d;
            hold_q  <= hold_d;
        end
    end

    assign tx_data   = data_q;
    assign tx_enable = en_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_sync_launcher.sv
// Scoreboard bench for mux_sync_launcher.
// Timeout scenario depends on MUX_SYNC_ACK_TIMEOUT_EN.
module tb_mux_sync_launcher;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int HOLD = 4;
    localparam int TOC  = 10;
    localparam int EXP_HOLD = (HOLD > SYNC + 1) ? HOLD : SYNC + 1;
`ifdef MUX_SYNC_ACK_TIMEOUT_EN
    localparam int EXP_PULSES = 1;
`else
    localparam int EXP_PULSES = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] tx_data;
    logic          tx_enable;
    logic          rx_ack = 1'b0;
    logic          busy;
    logic          timeout;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    logic [DW-1:0] sb[$];
    logic          en_prev   = 1'b0;
    logic          busy_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    mux_sync_launcher #(
        .DATA_W     (DW),
        .SYNC_STAGES(SYNC),
        .HOLD_MIN   (HOLD),
        .TIMEOUT_CYC(TOC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_enable(tx_enable),
        .rx_ack   (rx_ack),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepted words go into the scoreboard.
    always @(posedge clk) begin
        if (in_valid === 1'b1 && in_ready === 1'b1) begin
            sb.push_back(in_data);
            chk("acc_idle", 32'(busy), 32'(0));
        end
    end

    // Launch data check, frozen-data check, timeout pulse count.
    always @(negedge clk) begin
        if (tx_enable === 1'b1 && en_prev === 1'b0) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(1), 32'(0));
            end else begin
                chk("sb_data", 32'(tx_data), 32'(sb.pop_front()));
            end
        end
        if (busy === 1'b1 && busy_prev === 1'b1) begin
            chk("frozen", 32'(tx_data), 32'(data_prev));
        end
        if (timeout === 1'b1) pulses++;
        en_prev   = tx_enable;
        busy_prev = busy;
        data_prev = tx_data;
    end

    // Receiver side of one handshake, entered with tx_enable high.
    task automatic handshake(input int rise_dly, input int fall_dly,
                             input string tag);
        int n;
        repeat (rise_dly) tick();
        rx_ack = 1'b1;
        n = 0;
        while (tx_enable && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_drop"}, 32'(n), 32'(SYNC + 1));
        repeat (fall_dly) tick();
        rx_ack = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 32'(n), 32'(SYNC + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values
        tick();
        tick();
        chk("rst_en", 32'(tx_enable), 32'(0));
        chk("rst_data", 32'(tx_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_to", 32'(timeout), 32'(0));
        chk("rst_rdy", 32'(in_ready), 32'(0));
        reset = 1'b0;
        tick();
        chk("rel_rdy", 32'(in_ready), 32'(1));

        // 1 Basic
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_en", 32'(tx_enable), 32'(1));
        chk("t1_data", 32'(tx_data), 32'(8'hA5));
        chk("t1_rdy", 32'(in_ready), 32'(0));
        handshake(3, 3, "t1");
        chk("t1_rdy_end", 32'(in_ready), 32'(1));

        // 2 Back-to-back with in_valid held
        in_data  = 8'h11;
        in_valid = 1'b1;
        tick();
        in_data = 8'h22;
        chk("t2_data1", 32'(tx_data), 32'(8'h11));
        handshake(3, 3, "t2a");
        chk("t2_rdy", 32'(in_ready), 32'(1));
        chk("t2_en_gap", 32'(tx_enable), 32'(0));
        tick();
        in_valid = 1'b0;
        chk("t2_data2", 32'(tx_data), 32'(8'h22));
        chk("t2_en2", 32'(tx_enable), 32'(1));
        handshake(3, 3, "t2b");

        // 3 Fast ack, minimum hold
        in_data  = 8'h5A;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rx_ack   = 1'b1;
        n = 0;
        while (tx_enable && n < 50) begin
            tick();
            n++;
        end
        chk("t3_hold", 32'(n), 32'(EXP_HOLD));
        chk("t3_busy", 32'(busy), 32'(1));
        rx_ack = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("t3_idle", 32'(n), 32'(SYNC + 1));

        // 4 Reset mid-LAUNCH
        in_data  = 8'h77;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("t4_en", 32'(tx_enable), 32'(0));
        chk("t4_data", 32'(tx_data), 32'(0));
        chk("t4_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        tick();
        chk("t4_rdy", 32'(in_ready), 32'(1));
        in_data  = 8'h3C;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t4_data2", 32'(tx_data), 32'(8'h3C));
        handshake(3, 3, "t4");

        // 5 Ack stuck low
        in_data  = 8'h99;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef MUX_SYNC_ACK_TIMEOUT_EN
        n = 0;
        while (tx_enable && n < 50) begin
            tick();
            n++;
        end
        chk("t5_to_cyc", 32'(n), 32'(TOC));
        chk("t5_pulse", 32'(timeout), 32'(1));
        tick();
        chk("t5_pulse_end", 32'(timeout), 32'(0));
        chk("t5_idle", 32'(busy), 32'(0));
`else
        repeat (30) tick();
        chk("t5_en_held", 32'(tx_enable), 32'(1));
        chk("t5_no_to", 32'(timeout), 32'(0));
        handshake(1, 1, "t5");
`endif

        // 6 Stale ack across reset release
        reset  = 1'b1;
        rx_ack = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (SYNC + 1) tick();
        in_data  = 8'hE1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t6_rdy_low", 32'(in_ready), 32'(0));
            tick();
        end
        chk("t6_no_cap", 32'(sb.size()), 32'(0));
        rx_ack = 1'b0;
        n = 0;
        while (!tx_enable && n < 50) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("t6_accept", 32'(n), 32'(SYNC + 1));
        chk("t6_data", 32'(tx_data), 32'(8'hE1));
        handshake(3, 3, "t6");

        tick();
        chk("sb_left", 32'(sb.size()), 32'(0));
        chk("to_pulses", 32'(pulses), 32'(EXP_PULSES));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
